// File: rtl/converter_arbiter.sv
// Round-robin arbiter sharing one combinational binary-to-BCD converter between NUM_REQ requesters.
// Each accepted operand is converted, captured and returned with its requester id on one response port.
module converter_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [4*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [3:0]           conv_in,
   input  logic [7:0]           conv_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [7:0]           rsp_data,
   output logic                 busy,
   output logic                 conv_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              take;
   logic              capture;
   logic              grant_found;
   logic [ID_W-1:0]   grant_idx;
   int unsigned       cand;
   logic [3:0]        op_sel;
   logic [3:0]        op_reg;
   logic [ID_W-1:0]   id_reg;
   logic [ID_W-1:0]   rr_ptr;
   logic [7:0]        exp_bcd;
   logic              bad_capture;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = (32'(rr_ptr) + k) % NUM_REQ;
         if (!grant_found && req_valid[ID_W'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(cand);
         end
      end
   end

   // Operand mux and one-hot ready, offered only while idle
   always_comb begin
      op_sel    = '0;
      req_ready = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            op_sel       = req_data[4*i +: 4];
            req_ready[i] = grant_found && (state == IDLE);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      take       = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               take       = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            capture    = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Reference conversion of the held operand, used to vet the converter's answer
   always_comb begin
      if (op_reg > 4'd9) begin
         exp_bcd = {4'h1, op_reg - 4'd10};
      end else begin
         exp_bcd = {4'h0, op_reg};
      end
      bad_capture = (conv_out[7:4] > 4'd1) || (conv_out[3:0] > 4'd9) || (conv_out != exp_bcd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg   <= '0;
         id_reg   <= '0;
         rr_ptr   <= ID_W'(NUM_REQ - 1);
         rsp_data <= '0;
         rsp_id   <= '0;
         conv_err <= 1'b0;
      end else begin
         if (take) begin
            op_reg <= op_sel;
            id_reg <= grant_idx;
            rr_ptr <= grant_idx;
         end
         if (capture) begin
            rsp_data <= conv_out;
            rsp_id   <= id_reg;
            if (bad_capture) begin
               conv_err <= 1'b1;
            end
         end
      end
   end

   assign conv_in   = op_reg;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_converter_arbiter.sv
// Directed bench for converter_arbiter: vector table of single transactions plus
// multi-cycle sequences for back-to-back grants, backpressure, fairness, reset and converter faults.
module tb_converter_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;

   logic                 clk;
   logic                 rst;
   logic [NUM_REQ-1:0]   req_valid;
   logic [4*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic [3:0]           conv_in;
   logic [7:0]           conv_out;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [7:0]           rsp_data;
   logic                 busy;
   logic                 conv_err;
   logic                 force_bad;

   int checks;
   int errors;
   int cyc;

   converter_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .conv_in   (conv_in),
      .conv_out  (conv_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .conv_err  (conv_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] bcd(input logic [3:0] v);
      if (v > 4'd9) return {4'h1, v - 4'd10};
      return {4'h0, v};
   endfunction

   // Converter model, optionally corrupted for operand 4
   always_comb begin
      if (force_bad && conv_in == 4'd4) conv_out = 8'h1A;
      else conv_out = bcd(conv_in);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_txn(input logic [3:0] mask, input logic [15:0] data, input int id,
                         input logic [7:0] exp_rsp, input logic exp_err);
      logic [3:0] op;
      op = 4'(data >> (4 * id));
      @(posedge clk);
      #1 req_valid = mask; req_data = data; rsp_ready = 1'b0;
      @(negedge clk);
      check("grant", 32'(req_ready), 32'(1 << id));
      check("idle_busy", 32'(busy), 0);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check("load_busy", 32'(busy), 1);
      check("load_conv_in", 32'(conv_in), 32'(op));
      check("load_rsp_valid", 32'(rsp_valid), 0);
      check("load_ready", 32'(req_ready), 0);
      @(posedge clk);
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
      check("rsp_id", 32'(rsp_id), 32'(id));
      check("conv_err", 32'(conv_err), 32'(exp_err));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("post_rsp_valid", 32'(rsp_valid), 0);
      check("post_busy", 32'(busy), 0);
      check("post_conv_in", 32'(conv_in), 32'(op));
   endtask

   typedef struct {
      logic [3:0]  mask;
      logic [15:0] data;
      int          id;
      logic [7:0]  rsp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_t2[4];
      int         exp_t4[6];
      int         got_ids[6];
      int         n_got;
      int         prev;
      logic       got;
      logic       saw;
      logic       raised;

      checks = 0; errors = 0; cyc = 0;
      rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0; force_bad = 1'b0;

      // Vectors from reset; expected ids follow the round-robin pointer through the table
      vecs[0] = '{4'b0001, 16'h000D, 0, 8'h13};
      vecs[1] = '{4'b0011, 16'h0072, 1, 8'h07};
      vecs[2] = '{4'b0011, 16'h0070, 0, 8'h00};
      vecs[3] = '{4'b1111, 16'hF981, 1, 8'h08};
      vecs[4] = '{4'b1001, 16'hE005, 3, 8'h14};
      vecs[5] = '{4'b1000, 16'hA000, 3, 8'h10};
      vecs[6] = '{4'b0100, 16'h0900, 2, 8'h09};
      vecs[7] = '{4'b0101, 16'h0C01, 0, 8'h01};

      @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_conv_in", 32'(conv_in), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_conv_err", 32'(conv_err), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_txn(vecs[i].mask, vecs[i].data, vecs[i].id, vecs[i].rsp, 1'b0);
      end

      // All four valid with rsp_ready high: in-order grants, one response every 3 cycles
      do_reset();
      exp_t2 = '{8'h10, 8'h11, 8'h12, 8'h15};
      prev = 0;
      @(posedge clk);
      #1 req_valid = 4'hF; req_data = 16'hFCBA; rsp_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         got = 1'b0;
         for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
         end
         check("t2_rsp_seen", 32'(got), 1);
         check("t2_rsp_id", 32'(rsp_id), 32'(n));
         check("t2_rsp_data", 32'(rsp_data), 32'(exp_t2[n]));
         if (n > 0) check("t2_spacing", 32'(cyc - prev), 3);
         prev = cyc;
         if (n == 3) req_valid = '0;
      end
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // Backpressure: response held steady, no grants while other requesters wait
      do_reset();
      @(posedge clk);
      #1 req_valid = 4'b0010; req_data = 16'h0060;
      @(posedge clk);
      #1 req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b1101; req_data = 16'h7065;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t3_rsp_valid", 32'(rsp_valid), 1);
         check("t3_rsp_data", 32'(rsp_data), 'h06);
         check("t3_rsp_id", 32'(rsp_id), 1);
         check("t3_ready", 32'(req_ready), 0);
         check("t3_busy", 32'(busy), 1);
      end
      req_valid = '0; rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // Fairness: req1/req3 alternate; req0 raised after third response jumps ahead of req1
      do_reset();
      exp_t4 = '{1, 3, 1, 3, 0, 1};
      n_got = 0; raised = 1'b0;
      @(posedge clk);
      #1 req_valid = 4'b1010; req_data = 16'h703B; rsp_ready = 1'b1;
      for (int c = 0; c < 60 && n_got < 6; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got_ids[n_got] = int'(rsp_id);
            n_got++;
            if (n_got == 3 && !raised) begin
               req_valid[0] = 1'b1;
               raised = 1'b1;
            end
            if (n_got == 6) req_valid = '0;
         end
      end
      req_valid = '0;
      check("t4_count", 32'(n_got), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < n_got) check("t4_order", 32'(got_ids[k]), 32'(exp_t4[k]));
      end
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // Reset during LOAD drops the operand and restarts the pointer
      @(posedge clk);
      #1 req_valid = 4'b0100; req_data = 16'h0900;
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check("t5_load_conv_in", 32'(conv_in), 9);
      check("t5_load_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check("t5_rst_busy", 32'(busy), 0);
      check("t5_rst_conv_in", 32'(conv_in), 0);
      check("t5_rst_rsp_valid", 32'(rsp_valid), 0);
      check("t5_rst_rsp_data", 32'(rsp_data), 0);
      check("t5_rst_rsp_id", 32'(rsp_id), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid) saw = 1'b1;
      end
      check("t5_no_rsp", 32'(saw), 0);
      @(posedge clk);
      #1 req_valid = 4'b1010; req_data = 16'h5050;
      @(negedge clk);
      check("t5_first_grant", 32'(req_ready), 32'(4'b0010));
      req_valid = '0;

      // Faulty converter answer sets sticky conv_err, data passed through unchanged
      do_reset();
      force_bad = 1'b1;
      do_txn(4'b0001, 16'h0004, 0, 8'h1A, 1'b1);
      force_bad = 1'b0;
      do_txn(4'b0010, 16'h0030, 1, 8'h03, 1'b1);
      check("t6_sticky", 32'(conv_err), 1);
      do_reset();
      @(negedge clk);
      check("t6_cleared", 32'(conv_err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
